led_scan_decoder: RTL and testbench
===================================

Name: led_scan_decoder

Overview:
Registered N-to-2^N decoder driving an active-low LED bank, generalised from the fixed 3-to-8 enable-gated decoder. Adds parametrised select width and enable pattern, plus prescaled auto-scan modes (up, down, bounce) that sweep a single lit LED without host intervention. Sits between the board switch/enable inputs and the LED pins.

Parameters:
SEL_W, 3, select/index width; LED count OUT_W = 2**SEL_W (derived, not overridable)
EN_W, 3, width of enable input
EN_MATCH, 3'b100, enable value that activates the block; any other value blanks the LEDs
DIV_W, 16, prescaler width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
enable  input  EN_W  block active iff enable == EN_MATCH
mode  input  2  00 direct, 01 scan up, 10 scan down, 11 bounce
switch  input  SEL_W  direct-mode select; seed index on mode change
div  input  DIV_W  scan step period minus one, in clk cycles
led  output  OUT_W  active-low one-cold LED drive, registered
idx  output  SEL_W  current scan index, registered

Behaviour:
- Reset is synchronous and active-high on clk; it is sampled only at the rising edge. Reset values: led = all ones, idx = 0, prescaler cnt = 0, bounce dir = up, mode_q = 00. Reset mid-scan aborts immediately; there is no partial state.
- en = (enable == EN_MATCH). onehot(k) = 1 << k, OUT_W bits wide.
- Mode-change detect: mode != mode_q. mode_q <= mode every cycle.
- Direct (mode 00): led <= en ? ~onehot(switch) : all ones; one-cycle latency. idx <= switch. cnt held at 0.
- Scan modes (01/10/11), mode unchanged, en = 1:
  - cnt counts 0..div. At cnt == div: cnt <= 0 and a step occurs. Otherwise cnt <= cnt+1. div = 0 gives a step every cycle.
  - Up step: idx <= idx+1; wraps from OUT_W-1 to 0.
  - Down step: idx <= idx-1; wraps from 0 to OUT_W-1.
  - Bounce step, dir up: at idx == OUT_W-1, idx <= OUT_W-2 and dir <= down; else idx+1.
  - Bounce step, dir down: at idx == 0, idx <= 1 and dir <= up; else idx-1.
  - Bounce with SEL_W = 1 alternates 0,1,0,...
- Scan modes, en = 0: cnt, idx and dir hold; led <= all ones (blanked). Re-enabling resumes from the held cnt/idx.
- Any mode change, regardless of en: cnt <= 0, idx <= switch, dir <= up, no step that cycle. Mode change takes priority over step.
- LED/idx coherence: in scan modes led <= en ? ~onehot(idx_next) : all ones, where idx_next is the value idx takes at the same edge. led and idx therefore always agree when enabled.
- div changed mid-count: the new value is compared from the next cycle. If cnt > new div, cnt counts up and wraps through 2**DIV_W before stepping; this is defined behaviour, not an error.
- Exactly one led bit is low whenever en = 1 and not in reset.

Optional Feature:
LED_SCAN_TICK_EN: when defined, adds output port tick (1 bit). tick is a registered pulse, high for exactly the one cycle following each scan step, i.e. aligned with the new idx/led values. tick resets to 0 and is 0 in direct mode, when disabled, and on mode-change cycles. When the macro is undefined, the port and its logic are absent and all other behaviour is unchanged.

Test Plan:
- Reset: rst = 1 for 2 cycles with any inputs -> led = 8'hFF, idx = 0. After rst = 0, enable = 3'b100, mode = 00, switch = 5 -> led = 8'hDF one cycle later.
- Direct enable gating: switch = 2 with enable cycling through 0..7 -> led = 8'hFB only when enable = 4, 8'hFF otherwise, one-cycle latency each.
- Scan up: mode 00 -> 01 with switch = 6, div = 2 -> idx = 6 on the change edge, then 7, 0, 1 every 3 cycles; led = 8'hBF, 8'h7F, 8'hFE, 8'hFD.
- Bounce: mode 11, switch = 6, div = 0 -> idx sequence 6, 7, 6, 5, ..., 0, 1; no repeat at the endpoints.
- Disable/resume and mode priority: in scan up drop enable for 4 cycles -> led = 8'hFF, idx frozen, resumes stepping from the same idx/cnt. Change mode on the exact step cycle -> idx = switch, cnt = 0, no step.
- SEL_W = 4, EN_MATCH = 3'b001, mode 10, switch = 0 -> idx wraps 0 -> 15, led = 16'h7FFF. With LED_SCAN_TICK_EN defined, tick pulses once per step.

Source files
------------

// File: rtl/led_scan_decoder.sv
// led_scan_decoder: registered SEL_W-to-2**SEL_W decoder driving an
// active-low LED bank. It shows the switch value directly or runs one of
// three prescaled auto-scan modes (up, down, bounce) that sweep a single
// lit LED.
// Optional build macro LED_SCAN_TICK_EN adds a one-cycle 'tick' output.
// The tick is high in the cycle that follows each scan step.
module led_scan_decoder #(
    parameter int SEL_W = 3,
    parameter int EN_W  = 3,
    parameter logic [EN_W-1:0] EN_MATCH = 3'b100,
    parameter int DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EN_W-1:0]       enable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      switch,
    input  logic [DIV_W-1:0]      div,
    output logic [(2**SEL_W)-1:0] led,
    output logic [SEL_W-1:0]      idx
`ifdef LED_SCAN_TICK_EN
    ,
    output logic                  tick
`endif
);

    localparam int OUT_W = 2**SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    logic [OUT_W-1:0] r_led;
    logic [SEL_W-1:0] r_idx;
    logic [DIV_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode_q;

    logic             w_en;
    logic             w_mode_chg;
    logic             w_step;
    logic [SEL_W-1:0] w_idx_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic             w_dir_next;
    logic [OUT_W-1:0] w_led_next;

    assign w_en       = (enable == EN_MATCH);
    assign w_mode_chg = (mode != r_mode_q);

    // A scan step happens when the prescaler reaches div in a stable, enabled scan mode.
    always_comb begin
        w_step = 1'b0;
        if (mode != MODE_DIRECT && !w_mode_chg && w_en && r_cnt == div) begin
            w_step = 1'b1;
        end
    end

    // Next index/prescaler/direction. A mode change beats a step and reseeds from switch.
    always_comb begin
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (w_mode_chg) begin
            w_idx_next = switch;
            w_cnt_next = '0;
            w_dir_next = DIR_UP;
        end else if (mode == MODE_DIRECT) begin
            w_idx_next = switch;
            w_cnt_next = '0;
        end else if (w_en) begin
            if (w_step) begin
                w_cnt_next = '0;
                case (mode)
                    MODE_UP:   w_idx_next = r_idx + SEL_W'(1);
                    MODE_DOWN: w_idx_next = r_idx - SEL_W'(1);
                    MODE_BOUNCE: begin
                        if (r_dir == DIR_UP) begin
                            if (r_idx == IDX_MAX) begin
                                w_idx_next = IDX_MAX - SEL_W'(1);
                                w_dir_next = DIR_DOWN;
                            end else begin
                                w_idx_next = r_idx + SEL_W'(1);
                            end
                        end else begin
                            if (r_idx == '0) begin
                                w_idx_next = SEL_W'(1);
                                w_dir_next = DIR_UP;
                            end else begin
                                w_idx_next = r_idx - SEL_W'(1);
                            end
                        end
                    end
                    default: w_idx_next = r_idx;
                endcase
            end else begin
                w_cnt_next = r_cnt + DIV_W'(1);
            end
        end
    end

    // LED drive follows the index being registered this edge so led and idx stay coherent.
    always_comb begin
        w_led_next = '1;
        if (w_en) begin
            w_led_next = ~(OUT_W'(1) << w_idx_next);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= '1;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_dir    <= DIR_UP;
            r_mode_q <= MODE_DIRECT;
        end else begin
            r_led    <= w_led_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_dir    <= w_dir_next;
            r_mode_q <= mode;
        end
    end

    assign led = r_led;
    assign idx = r_idx;

`ifdef LED_SCAN_TICK_EN
    logic r_tick;

    // Tick marks the cycle in which a freshly stepped idx/led is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_step;
        end
    end

    assign tick = r_tick;
`endif

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: a default 3-bit instance and a
// 4-bit instance with a different enable pattern and a narrow prescaler.
// Build with LED_SCAN_TICK_EN defined to also check the tick output.
module tb_led_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [2:0]  en_a;
    logic [1:0]  mode_a;
    logic [2:0]  sw_a;
    logic [15:0] div_a;
    logic [7:0]  led_a;
    logic [2:0]  idx_a;

    logic [2:0]  en_b;
    logic [1:0]  mode_b;
    logic [3:0]  sw_b;
    logic [7:0]  div_b;
    logic [15:0] led_b;
    logic [3:0]  idx_b;

`ifdef LED_SCAN_TICK_EN
    logic tick_a;
    logic tick_b;
`endif

    led_scan_decoder u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .enable (en_a),
        .mode   (mode_a),
        .switch (sw_a),
        .div    (div_a),
        .led    (led_a),
        .idx    (idx_a)
`ifdef LED_SCAN_TICK_EN
        ,
        .tick   (tick_a)
`endif
    );

    led_scan_decoder #(
        .SEL_W    (4),
        .EN_W     (3),
        .EN_MATCH (3'b001),
        .DIV_W    (8)
    ) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .enable (en_b),
        .mode   (mode_b),
        .switch (sw_b),
        .div    (div_b),
        .led    (led_b),
        .idx    (idx_b)
`ifdef LED_SCAN_TICK_EN
        ,
        .tick   (tick_b)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] ei, input logic [7:0] el);
        check_eq({tag, ".idx"}, {29'd0, idx_a}, {29'd0, ei});
        check_eq({tag, ".led"}, {24'd0, led_a}, {24'd0, el});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] ei, input logic [15:0] el);
        check_eq({tag, ".idx"}, {28'd0, idx_b}, {28'd0, ei});
        check_eq({tag, ".led"}, {16'd0, led_b}, {16'd0, el});
    endtask

    task automatic chk_tick_a(input string tag, input logic et);
`ifdef LED_SCAN_TICK_EN
        check_eq({tag, ".tick"}, {31'd0, tick_a}, {31'd0, et});
`else
        if (et === 1'bx) $display("%s", tag);
`endif
    endtask

    task automatic chk_tick_b(input string tag, input logic et);
`ifdef LED_SCAN_TICK_EN
        check_eq({tag, ".tick"}, {31'd0, tick_b}, {31'd0, et});
`else
        if (et === 1'bx) $display("%s", tag);
`endif
    endtask

    // Scan up from 6 with div = 2: change edge, then a step every third edge.
    logic [2:0] up_idx  [10] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [7:0] up_led  [10] = '{8'hBF, 8'hBF, 8'hBF, 8'h7F, 8'h7F, 8'h7F, 8'hFE, 8'hFE, 8'hFE, 8'hFD};
    logic       up_tick [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Bounce from 6 with div = 0: no endpoint repeat.
    logic [2:0] bn_idx [11] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic [7:0] bn_led [11] = '{8'hBF, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD, 8'hFB};

    initial begin
        // Reset with arbitrary inputs.
        rst    = 1'b1;
        en_a   = 3'b100; mode_a = 2'b01; sw_a = 3'd3; div_a = 16'd0;
        en_b   = 3'b100; mode_b = 2'b00; sw_b = 4'd7; div_b = 8'd1;
        cyc();
        cyc();
        chk_a("reset_a", 3'd0, 8'hFF);
        chk_b("reset_b", 4'd0, 16'hFFFF);
        chk_tick_a("reset_a", 1'b0);

        // Direct mode after reset.
        rst = 1'b0; mode_a = 2'b00; sw_a = 3'd5;
        cyc();
        chk_a("direct_sw5", 3'd5, 8'hDF);

        // Enable gating: only 3'b100 lights the LED.
        sw_a = 3'd2;
        for (int e = 0; e < 8; e++) begin
            en_a = 3'(e);
            cyc();
            chk_a($sformatf("gate_en%0d", e), 3'd2, (e == 4) ? 8'hFB : 8'hFF);
            chk_tick_a("gate", 1'b0);
        end

        // Scan up.
        en_a = 3'b100; mode_a = 2'b01; sw_a = 3'd6; div_a = 16'd2;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_a($sformatf("scan_up_%0d", i), up_idx[i], up_led[i]);
            chk_tick_a($sformatf("scan_up_%0d", i), up_tick[i]);
        end

        // Disable: blank and freeze.
        en_a = 3'b000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_a($sformatf("disabled_%0d", i), 3'd1, 8'hFF);
            chk_tick_a("disabled", 1'b0);
        end

        // Resume from held cnt = 0, idx = 1.
        en_a = 3'b100;
        cyc(); chk_a("resume_0", 3'd1, 8'hFD);
        cyc(); chk_a("resume_1", 3'd1, 8'hFD);
        cyc(); chk_a("resume_2", 3'd2, 8'hFB);
        cyc(); chk_a("pre_chg_0", 3'd2, 8'hFB);
        cyc(); chk_a("pre_chg_1", 3'd2, 8'hFB);

        // Mode change on the exact step edge: reseed, no step, cnt cleared.
        mode_a = 2'b10; sw_a = 3'd5;
        cyc(); chk_a("chg_on_step", 3'd5, 8'hDF);
        chk_tick_a("chg_on_step", 1'b0);
        cyc(); chk_a("down_0", 3'd5, 8'hDF);
        cyc(); chk_a("down_1", 3'd5, 8'hDF);
        cyc(); chk_a("down_2", 3'd4, 8'hEF);

        // Bounce.
        mode_a = 2'b11; sw_a = 3'd6; div_a = 16'd0;
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk_a($sformatf("bounce_%0d", i), bn_idx[i], bn_led[i]);
            chk_tick_a($sformatf("bounce_%0d", i), i != 0);
        end

        // Back to direct, then a mode change while disabled still reseeds.
        mode_a = 2'b00; sw_a = 3'd3;
        cyc(); chk_a("direct_back", 3'd3, 8'hF7);
        en_a = 3'b000; mode_a = 2'b01; sw_a = 3'd4;
        cyc(); chk_a("chg_disabled", 3'd4, 8'hFF);
        en_a = 3'b100;
        cyc(); chk_a("chg_disabled_resume", 3'd5, 8'hDF);

        // Second instance: 4-bit select, enable pattern 3'b001.
        cyc(); chk_b("b_gate_off", 4'd7, 16'hFFFF);
        en_b = 3'b001;
        cyc(); chk_b("b_gate_on", 4'd7, 16'hFF7F);
        mode_b = 2'b10; sw_b = 4'd0; div_b = 8'd1;
        cyc(); chk_b("b_down_chg", 4'd0, 16'hFFFE); chk_tick_b("b_down_chg", 1'b0);
        cyc(); chk_b("b_down_0", 4'd0, 16'hFFFE);  chk_tick_b("b_down_0", 1'b0);
        cyc(); chk_b("b_down_1", 4'd15, 16'h7FFF); chk_tick_b("b_down_1", 1'b1);
        cyc(); chk_b("b_down_2", 4'd15, 16'h7FFF); chk_tick_b("b_down_2", 1'b0);
        cyc(); chk_b("b_down_3", 4'd14, 16'hBFFF); chk_tick_b("b_down_3", 1'b1);

        // div lowered below the running count: cnt wraps through 2**8 first.
        div_b = 8'd5;
        repeat (4) cyc();
        chk_b("b_cnt4", 4'd14, 16'hBFFF);
        div_b = 8'd1;
        repeat (253) cyc();
        chk_b("b_wrap_hold", 4'd14, 16'hBFFF);
        cyc();
        chk_b("b_wrap_step", 4'd13, 16'hDFFF);
        chk_tick_b("b_wrap_step", 1'b1);

        // Reset mid-scan aborts immediately.
        rst = 1'b1;
        cyc();
        chk_a("reset_mid_a", 3'd0, 8'hFF);
        chk_b("reset_mid_b", 4'd0, 16'hFFFF);
        chk_tick_b("reset_mid_b", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
